// File: rtl/maxpool_pkg.sv
// Shared constants, phase encoding and signed-max helper for the 2x2 max-pool stream stage.
package maxpool_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int IMG_W_DEF    = 28;
    localparam int IMG_H_DEF    = 28;
    localparam int CHANNELS_DEF = 6;

    localparam int COL_W_DEF = $clog2(IMG_W_DEF);
    localparam int ROW_W_DEF = $clog2(IMG_H_DEF);
    localparam int CH_W_DEF  = $clog2(CHANNELS_DEF);

    // Widest pixel the shared compare supports; narrower pixels are sign-extended into it.
    localparam int SMAX_W = 64;

    // Window position of the current input pixel, encoded as {row[0], col[0]}.
    typedef enum logic [1:0] {
        PH_TOP_LEFT  = 2'b00,
        PH_TOP_RIGHT = 2'b01,
        PH_BOT_LEFT  = 2'b10,
        PH_BOT_RIGHT = 2'b11
    } phase_e;

    // $clog2 floored at 1 so single-entry dimensions still get a real counter bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a,
                                                      input logic signed [SMAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_2x2_stream_if.sv
// Valid/ready pixel stream with frame marker, shared by the pool stage input and output.
interface maxpool_2x2_stream_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/maxpool_line_buf.sv
// Half-row line buffer: one write port, one combinational read port; contents are not reset.
module maxpool_line_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 14,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool stage: raster-order, channel-major pixels in,
// pooled pixels out through a single registered slot with valid/ready handshake.
module maxpool_2x2_stream
    import maxpool_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int CHANNELS = CHANNELS_DEF
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    maxpool_2x2_stream_if.slave  s_axis,
    maxpool_2x2_stream_if.master m_axis,
    output logic                 frame_done,
    output logic                 tlast_err
);

    localparam int COL_W    = cnt_w(IMG_W);
    localparam int ROW_W    = cnt_w(IMG_H);
    localparam int CH_W     = cnt_w(CHANNELS);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = cnt_w(LB_DEPTH);

    if (IMG_W % 2 != 0) begin : g_img_w_odd
        $error("maxpool_2x2_stream: IMG_W must be even");
    end
    if (IMG_H % 2 != 0) begin : g_img_h_odd
        $error("maxpool_2x2_stream: IMG_H must be even");
    end
    if (DATA_W > SMAX_W) begin : g_data_w_wide
        $error("maxpool_2x2_stream: DATA_W exceeds signed compare width");
    end

    function automatic logic [DATA_W-1:0] max_px(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return DATA_W'(smax(SMAX_W'($signed(a)), SMAX_W'($signed(b))));
    endfunction

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] hreg;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] win_max;
    logic [DATA_W-1:0] lb_rd_data;
    logic [LB_AW-1:0]  lb_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              in_xfer;
    logic              out_xfer;
    logic              col_last;
    logic              row_last;
    logic              ch_last;
    logic              frame_pos_last;
    phase_e            phase;

    assign s_axis.tready = !out_valid || m_axis.tready;
    assign in_xfer       = s_axis.tvalid && s_axis.tready;
    assign out_xfer      = out_valid && m_axis.tready;

    assign m_axis.tdata  = out_data;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;

    assign col_last       = (col == COL_W'(IMG_W - 1));
    assign row_last       = (row == ROW_W'(IMG_H - 1));
    assign ch_last        = (ch == CH_W'(CHANNELS - 1));
    assign frame_pos_last = col_last && row_last && ch_last;

    assign phase    = phase_e'({row[0], col[0]});
    assign lb_addr  = LB_AW'(col >> 1);
    assign pair_max = max_px(hreg, s_axis.tdata);
    assign win_max  = max_px(lb_rd_data, pair_max);

    // Even rows park the horizontal pair max; the odd row below reads it back at the same column.
    maxpool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .ADDR_W (LB_AW)
    ) u_line_buf (
        .clk     (ap_clk),
        .wr_en   (in_xfer && (phase == PH_TOP_RIGHT)),
        .wr_addr (lb_addr),
        .wr_data (pair_max),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            col <= '0;
            row <= '0;
            ch  <= '0;
        end else if (in_xfer) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                    ch  <= ch_last ? '0 : ch + CH_W'(1);
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            hreg <= '0;
        end else if (in_xfer && !col[0]) begin
            hreg <= s_axis.tdata;
        end
    end

    // A new pooled pixel takes priority over clearing the slot on the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_xfer && (phase == PH_BOT_RIGHT)) begin
            out_data  <= win_max;
            out_valid <= 1'b1;
            out_last  <= frame_pos_last;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            frame_done <= 1'b0;
            tlast_err  <= 1'b0;
        end else begin
            frame_done <= out_xfer && out_last;
            if (in_xfer && (s_axis.tlast != frame_pos_last)) begin
                tlast_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Randomized bench for the 2x2 max-pool stream stage against a frame-level reference model.
`timescale 1ns/1ps
module tb_maxpool_2x2_stream;

    localparam int BW      = 28;
    localparam int BH      = 28;
    localparam int BC      = 6;
    localparam int BIG_N   = BW * BH * BC;
    localparam int BIG_OUT = BIG_N / 4;
    localparam int BUDGET  = 40000;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        bit          last;
        int          cyc;
    } cap_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic big_done, big_err, small_done, small_err;

    maxpool_2x2_stream_if #(.DATA_W(32)) bs ();
    maxpool_2x2_stream_if #(.DATA_W(32)) bm ();
    maxpool_2x2_stream_if #(.DATA_W(32)) ss ();
    maxpool_2x2_stream_if #(.DATA_W(32)) sm ();

    maxpool_2x2_stream #(.DATA_W(32), .IMG_W(BW), .IMG_H(BH), .CHANNELS(BC)) u_big (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .s_axis     (bs),
        .m_axis     (bm),
        .frame_done (big_done),
        .tlast_err  (big_err)
    );

    maxpool_2x2_stream #(.DATA_W(32), .IMG_W(4), .IMG_H(4), .CHANNELS(1)) u_small (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .s_axis     (ss),
        .m_axis     (sm),
        .frame_done (small_done),
        .tlast_err  (small_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each pooled pixel is the largest of its four window pixels.
    int   frame_px[$];
    exp_t model_q[$];

    task automatic build_model(input int w, input int h, input int nch);
        model_q.delete();
        for (int c = 0; c < nch; c++)
            for (int r = 0; r < h; r += 2)
                for (int x = 0; x < w; x += 2) begin
                    int best;
                    exp_t e;
                    best = frame_px[(c * h + r) * w + x];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dx = 0; dx < 2; dx++)
                            if (frame_px[(c * h + r + dr) * w + x + dx] > best)
                                best = frame_px[(c * h + r + dr) * w + x + dx];
                    e.data = 32'(best);
                    e.last = (c == nch - 1) && (r == h - 2) && (x == w - 2);
                    model_q.push_back(e);
                end
    endtask

    task automatic random_frame(input int n);
        frame_px.delete();
        for (int i = 0; i < n; i++) frame_px.push_back(int'($urandom()));
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Small instance: capture everything, judged after each frame.
    cap_t cap_q[$];
    int   done_cyc_q[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (sm.tvalid && sm.tready) cap_q.push_back('{sm.tdata, sm.tlast, cyc});
            if (small_done) done_cyc_q.push_back(cyc);
        end
    end

    // Large instance: live scoreboard with hold and frame_done checks.
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_out = 0;
    int          n_last = 0;
    bit          done_due = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    bit          prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_due   = 0;
            prev_stall = 0;
        end else begin
            check_eq("frame_done", big_done, done_due);
            if (prev_stall) begin
                check_eq("hold_valid", bm.tvalid, 1);
                check_eq("hold_data", bm.tdata, prev_data);
                check_eq("hold_last", bm.tlast, prev_last);
            end
            if (bm.tvalid && !bm.tready) check_eq("stall_s_tready", bs.tready, 0);
            if (bm.tvalid && bm.tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_output", bm.tdata, 32'hxxxx_xxxx);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_data", bm.tdata, mon_e.data);
                    check_eq("out_last", bm.tlast, mon_e.last);
                    n_out++;
                    if (bm.tlast) n_last++;
                end
            end
            done_due   = bm.tvalid && bm.tready && bm.tlast;
            prev_stall = bm.tvalid && !bm.tready;
            prev_data  = bm.tdata;
            prev_last  = bm.tlast;
        end
    end

    task automatic drive_small(output int last_acc);
        last_acc = -1;
        for (int i = 0; i < 16; i++) begin
            ss.tvalid = 1'b1;
            ss.tdata  = 32'(frame_px[i]);
            ss.tlast  = (i == 15);
            @(negedge clk);
            check_eq("small_s_tready", ss.tready, 1);
            @(posedge clk);
            #1;
        end
        last_acc  = cyc;
        ss.tvalid = 1'b0;
        ss.tlast  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drive_big(input int npix, input int err_idx, input bit hold_bp,
                             input int rdy_pct, input bit drain);
        int  i = 0;
        int  spent = 0;
        int  hold = 0;
        bit  armed = hold_bp;
        bit  acc;
        while (i < npix) begin
            bs.tvalid = ($urandom_range(0, 9) != 0);
            bs.tdata  = 32'(frame_px[i]);
            bs.tlast  = (i == err_idx) || (i == BIG_N - 1);
            if (armed && bm.tvalid) begin
                hold  = 10;
                armed = 0;
            end
            if (hold > 0) begin
                bm.tready = 1'b0;
                hold--;
            end else begin
                bm.tready = ($urandom_range(0, 99) < rdy_pct);
            end
            @(negedge clk);
            acc = bs.tvalid && bs.tready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                if (err_idx >= 0 && i == err_idx) check_eq("tlast_err_before", big_err, 0);
                if (err_idx >= 0 && i == err_idx + 1) check_eq("tlast_err_set", big_err, 1);
            end
            spent++;
            if (spent > BUDGET) begin
                $display("FAIL drive_budget: accepted %0d of %0d pixels", i, npix);
                $fatal(1, "input stall");
            end
        end
        bs.tvalid = 1'b0;
        bs.tlast  = 1'b0;
        if (drain) begin
            bm.tready = 1'b1;
            spent = 0;
            while ((exp_q.size() != 0 || bm.tvalid) && spent < 100) begin
                @(posedge clk);
                #1;
                spent++;
            end
            check_eq("drain_left", exp_q.size(), 0);
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_big_frame(input int err_idx, input bit hold_bp, input int rdy_pct,
                                 input bit exp_err);
        random_frame(BIG_N);
        build_model(BW, BH, BC);
        exp_q  = model_q;
        n_out  = 0;
        n_last = 0;
        drive_big(BIG_N, err_idx, hold_bp, rdy_pct, 1'b1);
        check_eq("big_out_count", n_out, BIG_OUT);
        check_eq("big_last_count", n_last, 1);
        check_eq("big_tlast_err", big_err, exp_err);
    endtask

    int last_acc;
    int exp_vals[4] = '{5, 7, 13, 15};

    initial begin
        bs.tvalid = 0; bs.tdata = 0; bs.tlast = 0; bm.tready = 0;
        ss.tvalid = 0; ss.tdata = 0; ss.tlast = 0; sm.tready = 1;

        #12;
        check_eq("rst_m_tvalid", bm.tvalid, 0);
        check_eq("rst_m_tdata", bm.tdata, 0);
        check_eq("rst_m_tlast", bm.tlast, 0);
        check_eq("rst_frame_done", big_done, 0);
        check_eq("rst_tlast_err", big_err, 0);
        check_eq("rst_s_tready", bs.tready, 1);
        check_eq("rst_small_tvalid", sm.tvalid, 0);
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4x4 ramp 0..15
        frame_px.delete();
        for (int i = 0; i < 16; i++) frame_px.push_back(i);
        cap_q.delete();
        done_cyc_q.delete();
        drive_small(last_acc);
        check_eq("ramp_count", cap_q.size(), 4);
        for (int k = 0; k < 4 && k < cap_q.size(); k++) begin
            check_eq("ramp_data", cap_q[k].data, 32'(exp_vals[k]));
            check_eq("ramp_last", cap_q[k].last, (k == 3));
        end
        if (cap_q.size() == 4) check_eq("ramp_latency", cap_q[3].cyc, last_acc);
        check_eq("ramp_done_count", done_cyc_q.size(), 1);
        if (done_cyc_q.size() == 1) check_eq("ramp_done_cycle", done_cyc_q[0], last_acc + 1);
        check_eq("ramp_tlast_err", small_err, 0);

        // Signed window in the top-left corner
        random_frame(16);
        frame_px[0] = -8;
        frame_px[1] = -3;
        frame_px[4] = -5;
        frame_px[5] = -20;
        build_model(4, 4, 1);
        cap_q.delete();
        drive_small(last_acc);
        check_eq("signed_count", cap_q.size(), 4);
        if (cap_q.size() > 0) check_eq("signed_first", cap_q[0].data, 32'hFFFF_FFFD);
        for (int k = 0; k < 4 && k < cap_q.size(); k++)
            check_eq("signed_model", cap_q[k].data, model_q[k].data);

        // Full S2 frames: backpressure hold first, then a misplaced s_tlast
        run_big_frame(-1, 1'b1, 50, 1'b0);
        run_big_frame(100, 1'b0, 50, 1'b1);

        // Reset in the middle of row 7 of channel 0
        random_frame(BIG_N);
        build_model(BW, BH, BC);
        exp_q = model_q;
        drive_big(7 * BW + 11, -1, 1'b0, 50, 1'b0);
        bm.tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_m_tvalid", bm.tvalid, 0);
        check_eq("midrst_m_tdata", bm.tdata, 0);
        check_eq("midrst_tlast_err", big_err, 0);
        check_eq("midrst_s_tready", bs.tready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        run_big_frame(-1, 1'b0, 100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
